// File: rtl/desplazamiento_pkg.sv
// desplazamiento_pkg
// Shared definitions for the displacement-sample generator:
//   - default widths of the displacement word and of the period/counter words
//   - default heartbeat interval (clock cycles between strobes when idle)
//   - control state enumeration
package desplazamiento_pkg;

    localparam int          ANCHO_DESP_DEF    = 32'd16;
    localparam int          ANCHO_PERIODO_DEF = 32'd32;
    localparam int unsigned LATIDO_DEF        = 32'd500000000;

    typedef enum logic [1:0] {
        INACTIVO  = 2'd0,   // no stepping
        CARGA     = 2'd1,   // one cycle: new period takes effect
        CORRIENDO = 2'd2    // stepping at the active period
    } estado_t;

endpackage

// File: rtl/contador_periodo.sv
// contador_periodo
// Compare-and-reset counter. It counts up while enabled, wraps to zero after
// reaching the limit, and raises a terminal-count flag in the cycle where the
// counter sits on the limit and is enabled. The flag is combinational; the
// owner registers whatever it drives from it.
// Ports:
//   clock     - clock
//   reset     - asynchronous active-high reset (count -> 0)
//   borrar    - synchronous clear, wins over counting
//   habilitar - count enable; 0 holds the count
//   limite    - terminal value (count runs 0..limite)
//   fin       - terminal-count flag
module contador_periodo
    import desplazamiento_pkg::*;
#(
    parameter int ANCHO = ANCHO_PERIODO_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             borrar,
    input  logic             habilitar,
    input  logic [ANCHO-1:0] limite,
    output logic             fin
);

    logic [ANCHO-1:0] cuenta_r;

    // Count register: clear has priority, then wrap at the limit or increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cuenta_r <= {ANCHO{1'b0}};
        end else if (borrar) begin
            cuenta_r <= {ANCHO{1'b0}};
        end else if (habilitar) begin
            if (cuenta_r == limite) begin
                cuenta_r <= {ANCHO{1'b0}};
            end else begin
                cuenta_r <= cuenta_r + ANCHO'(1);
            end
        end
    end

    assign fin = habilitar & ~borrar & (cuenta_r == limite);

endmodule

// File: rtl/generador_desplazamiento.sv
// generador_desplazamiento
// Source end of the displacement interface. A step period (clock cycles per
// displacement unit) is loaded over a valid/ready handshake; while running,
// the displacement moves by +/-1 once per period and `impulso` strobes with
// each update. With no step for LATIDO cycles a heartbeat strobe is issued
// with the displacement unchanged.
// Ports:
//   clock, reset    - clock, asynchronous active-high reset
//   periodo_data    - commanded cycles per step (0 = stop)
//   periodo_valid   - periodo_data valid
//   periodo_ready   - block can accept a period (low only in the load cycle)
//   habilitar       - 1 runs the step counter, 0 freezes it
//   sentido         - 1 increments, 0 decrements (sampled at each step)
//   desplazamiento  - current displacement (registered)
//   impulso         - one-cycle strobe on each step or heartbeat
//   periodo_activo  - period currently in force
//   vuelta          - one-cycle pulse when a step wraps the displacement
module generador_desplazamiento
    import desplazamiento_pkg::*;
#(
    parameter int          ANCHO_DESP    = ANCHO_DESP_DEF,
    parameter int          ANCHO_PERIODO = ANCHO_PERIODO_DEF,
    parameter int unsigned LATIDO        = LATIDO_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ANCHO_PERIODO-1:0] periodo_data,
    input  logic                     periodo_valid,
    output logic                     periodo_ready,
    input  logic                     habilitar,
    input  logic                     sentido,
    output logic [ANCHO_DESP-1:0]    desplazamiento,
    output logic                     impulso,
    output logic [ANCHO_PERIODO-1:0] periodo_activo,
    output logic                     vuelta
);

    localparam logic [ANCHO_PERIODO-1:0] LIMITE_LATIDO = ANCHO_PERIODO'(LATIDO - 32'd1);

    estado_t                  estado_r;
    logic [ANCHO_DESP-1:0]    desp_r;
    logic [ANCHO_PERIODO-1:0] periodo_activo_r;
    logic                     ready_r;
    logic                     impulso_r;
    logic                     vuelta_r;

    logic                     transferencia_s;
    logic                     carga_s;
    logic                     paso_hab_s;
    logic [ANCHO_PERIODO-1:0] limite_paso_s;
    logic                     paso_s;
    logic                     latido_s;
    logic [ANCHO_DESP-1:0]    desp_sig_s;
    logic                     vuelta_sig_s;

    assign transferencia_s = periodo_valid & ready_r;
    assign carga_s         = (estado_r == CARGA);
    assign paso_hab_s      = (estado_r == CORRIENDO) & habilitar;
    // Count runs 0..P-1, so a period of P cycles ends at P-1.
    assign limite_paso_s   = periodo_activo_r - ANCHO_PERIODO'(1);

    contador_periodo #(.ANCHO(ANCHO_PERIODO)) u_contador_paso (
        .clock     (clock),
        .reset     (reset),
        .borrar    (carga_s),
        .habilitar (paso_hab_s),
        .limite    (limite_paso_s),
        .fin       (paso_s)
    );

    // The heartbeat restarts on every step strobe, so it only fires when idle.
    contador_periodo #(.ANCHO(ANCHO_PERIODO)) u_contador_latido (
        .clock     (clock),
        .reset     (reset),
        .borrar    (paso_s),
        .habilitar (1'b1),
        .limite    (LIMITE_LATIDO),
        .fin       (latido_s)
    );

    // Next displacement value and wrap detection for the current direction.
    always_comb begin
        desp_sig_s   = desp_r;
        vuelta_sig_s = 1'b0;
        if (sentido) begin
            desp_sig_s   = desp_r + ANCHO_DESP'(1);
            vuelta_sig_s = (desp_r == {ANCHO_DESP{1'b1}});
        end else begin
            desp_sig_s   = desp_r - ANCHO_DESP'(1);
            vuelta_sig_s = (desp_r == {ANCHO_DESP{1'b0}});
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r         <= INACTIVO;
            desp_r           <= {ANCHO_DESP{1'b0}};
            periodo_activo_r <= {ANCHO_PERIODO{1'b0}};
            ready_r          <= 1'b1;
            impulso_r        <= 1'b0;
            vuelta_r         <= 1'b0;
        end else begin
            // A coincident step and heartbeat merge into a single strobe.
            impulso_r <= paso_s | latido_s;
            vuelta_r  <= paso_s & vuelta_sig_s;
            if (paso_s) begin
                desp_r <= desp_sig_s;
            end
            case (estado_r)
                INACTIVO, CORRIENDO: begin
                    // A reload while running drops the partial period; the
                    // counter is cleared in the following CARGA cycle.
                    if (transferencia_s) begin
                        periodo_activo_r <= periodo_data;
                        estado_r         <= CARGA;
                        ready_r          <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                CARGA: begin
                    ready_r <= 1'b1;
                    if (periodo_activo_r != {ANCHO_PERIODO{1'b0}}) begin
                        estado_r <= CORRIENDO;
                    end else begin
                        estado_r <= INACTIVO;
                    end
                end
                default: begin
                    estado_r <= INACTIVO;
                    ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign periodo_ready  = ready_r;
    assign desplazamiento = desp_r;
    assign periodo_activo = periodo_activo_r;
    assign impulso        = impulso_r;
    assign vuelta         = vuelta_r;

endmodule
